// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage: holds SR/Cause/EPC/PRId,
// raises a combinational req that flushes the pipe and latches the exception context.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID_VAL   = 32'h0000_0000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pcM,
  input  logic [4:0]  ExcCodeM,
  input  logic        bdM,
  input  logic        validM,
  input  logic [5:0]  HWInt,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        eret,
  output logic [31:0] rdata,
  output logic        req,
  output logic [31:0] epc,
  output logic [31:0] handler_pc
);
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic        int_req, exc_req;
  logic [31:0] sr_w, cause_w;

  // Bubbles carry the flushed slot's pc/bd, so interrupts need not look at validM.
  logic unused_validm;
  assign unused_validm = validM;

  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCodeM != 5'd0) & ~exl_q;
  assign req     = int_req | exc_req;

  assign sr_w    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_w = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};

  assign epc        = epc_q;
  assign handler_pc = HANDLER_PC;

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    ip_d      = HWInt;
    if (req) begin
      exl_d     = 1'b1;
      bd_d      = bdM;
      exccode_d = int_req ? 5'd0 : ExcCodeM;
      epc_d     = bdM ? pcM - 32'd4 : pcM;
    end else begin
      if (we && addr == 5'd12) begin
        im_d  = wdata[15:10];
        exl_d = wdata[1];
        ie_d  = wdata[0];
      end
      if (we && addr == 5'd14) epc_d = wdata;
      // eret clears EXL after any same-cycle SR write
      if (eret) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

  always_comb begin
    case (addr)
      5'd12:   rdata = sr_w;
      5'd13:   rdata = cause_w;
      5'd14:   rdata = epc_q;
      5'd15:   rdata = PRID_VAL;
      default: rdata = 32'd0;
    endcase
  end
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline, sitting at the memory stage.
- Consumes the per-instruction exception tags (exception code, branch-delay flag, PC, valid) that the pipeline registers carry forward.
- Produces the pipeline-wide `req` that flushes the ID/EX, EX/MEM and MEM/WB registers and redirects fetch to the handler.
- Holds SR, Cause, EPC and PRId for mfc0/mtc0/eret.

Parameters:
- PRID_VAL, 32'h0000_0000, constant returned on reads of register 15.
- HANDLER_PC, 32'h0000_4180, handler entry address output on `handler_pc`.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pcM  in  32  PC of the instruction in the M stage.
- ExcCodeM  in  5  exception code tagged on the M-stage instruction; 0 = none.
- bdM  in  1  M-stage instruction is in a branch delay slot; bubbles created by a flush keep the bd of the flushed slot.
- validM  in  1  M stage holds a real instruction, not a bubble.
- HWInt  in  6  external hardware interrupt lines, level-sensitive.
- we  in  1  mtc0 write enable (M stage).
- addr  in  5  CP0 register number for mtc0/mfc0.
- wdata  in  32  mtc0 write data.
- eret  in  1  eret is in the M stage.
- rdata  out  32  mfc0 read data, combinational from `addr`.
- req  out  1  take exception/interrupt this cycle, combinational.
- epc  out  32  current EPC, for the eret target.
- handler_pc  out  32  equals HANDLER_PC.

Behaviour:
- State registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC (14): 32 bits.
- Reset (reset=0, asynchronous): SR=0, Cause=0, EPC=0. `req` then evaluates to 0 because IE=0 and there are no pending codes while the pipeline is reset.
- Interrupt pending: `int_req = |(HWInt & SR.IM) & SR.IE & ~SR.EXL`.
- Exception pending: `exc_req = (ExcCodeM != 0) & ~SR.EXL`.
- `req = int_req | exc_req`; zero latency, combinational in the same cycle.
- Priority: an interrupt beats a simultaneous synchronous exception; the recorded code is then 0.
- Interrupts are taken regardless of `validM`. A bubble carries the correct bd/pc from flush propagation, so EPC stays correct.
- On a clock edge with `req=1`:
  - SR.EXL<=1.
  - Cause.BD<=bdM.
  - Cause.ExcCode<= int_req ? 0 : ExcCodeM.
  - EPC <= bdM ? pcM-4 : pcM, in 32-bit wrap-around arithmetic (pcM=0 with bdM=1 gives 32'hFFFF_FFFC).
- Cause.IP <= HWInt every cycle, unconditionally. IP is read-only.
- mtc0 (`we=1`, `req=0`):
  - addr 12: SR <= wdata masked to {IM,EXL,IE}.
  - addr 14: EPC <= wdata.
  - Any other addr: ignored. Cause and PRId are not writable.
- `req=1` in the same cycle as `we=1`: the write is dropped and exception capture wins.
- eret (`eret=1`, `req=0`): SR.EXL<=0 at the edge. If mtc0 to SR occurs in the same cycle, the write is applied first and EXL is then forced to 0.
- `eret` with `req=1`: `req` wins and EXL stays 1.
- While EXL=1, `req` is 0 for all inputs; a nested exception is never taken.
- `rdata`:
  - addr 12 gives SR, 13 gives Cause, 14 gives EPC, 15 gives PRID_VAL, any other addr gives 0.
  - Reads return the pre-edge value; a same-cycle write is not bypassed.
- `epc` mirrors the EPC register.
- Reset asserted mid-operation clears all state immediately, including a pending EXL and a captured EPC.

Test Plan:
- Release reset; drive ExcCodeM=0, HWInt=0 -> req=0, rdata(12)=0, rdata(13)=0, rdata(14)=0, rdata(15)=PRID_VAL.
- mtc0 SR=32'h0000_FC01, then HWInt=6'b000100 -> req=1 in the same cycle; after the edge Cause=32'h0000_1000 (IP[12] set, ExcCode=0), EXL=1, and req drops to 0 while HWInt is held.
- ExcCodeM=5'd4, pcM=32'h0000_3008, bdM=1, EXL=0 -> req=1; after the edge EPC=32'h0000_3004, Cause[31]=1, Cause[6:2]=4.
- Same cycle: HWInt enabled and ExcCodeM=5'd10 -> Cause.ExcCode=0 (interrupt priority); EPC=pcM.
- Same cycle: req=1, we=1, addr=14, wdata=32'hDEAD_BEEF -> EPC gets the exception PC, not DEAD_BEEF. Next cycle: eret=1 -> EXL=0, and a held interrupt re-asserts req.
- With EXL=1 and EPC=32'h3000, pulse reset low between clock edges -> SR, Cause and EPC read 0 immediately, before the next edge.
